// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic, arithmetic, compare and
// shift ops plus iterative shift-add multiply and restoring divide.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             flag_dz,
  output logic             flag_illegal,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH);

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_LTU = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_LTS = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic               w_accept;
  logic               w_iter_op;
  logic               w_last_step;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_res_hi;
  logic               w_c;
  logic               w_v;
  logic               w_dz;
  logic               w_ill;

  logic               r_is_div;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;

  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;
  logic               r_dz;
  logic               r_ill;

  assign in_ready    = (r_state == S_IDLE) ||
                       ((r_state == S_DONE) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_iter_op   = (op == OP_MUL) ||
                       ((op == OP_DIV) && (operand_b != '0));
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_shamt     = operand_b[SHAMT_W-1:0];
  assign w_sum       = {1'b0, operand_a} + {1'b0, operand_b};
  assign w_dif       = {1'b0, operand_a} - {1'b0, operand_b};

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_dz     = 1'b0;
    w_ill    = 1'b0;
    case (op)
      OP_NOT: w_res = ~operand_a;
      OP_AND: w_res = operand_a & operand_b;
      OP_OR:  w_res = operand_a | operand_b;
      OP_XOR: w_res = operand_a ^ operand_b;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                (w_dif[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_LTU: w_res = WIDTH'(operand_a < operand_b);
      OP_EQ:  w_res = WIDTH'(operand_a == operand_b);
      OP_LTS: w_res = WIDTH'($signed(operand_a) < $signed(operand_b));
      OP_SHL: w_res = operand_a << w_shamt;
      OP_SHR: w_res = operand_a >> w_shamt;
      OP_SRA: w_res = $unsigned($signed(operand_a) >>> w_shamt);
      OP_MUL: w_res = '0;
      OP_DIV: begin
        // only the divide-by-zero case completes without iterating
        if (operand_b == '0) begin
          w_res    = '1;
          w_res_hi = operand_a;
          w_dz     = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_opnd};

  always_comb begin
    w_step_hi = w_madd[WIDTH:1];
    w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      // r_lo shifts dividend bits out the top and quotient bits in
      if (!w_trial[WIDTH]) begin
        w_step_hi = w_trial[WIDTH-1:0];
        w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_shift[WIDTH-1:0];
        w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_iter_op ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        if (w_last_step) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next_state = w_iter_op ? S_EXEC : S_DONE;
        end else if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_is_div    <= 1'b0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_dz        <= 1'b0;
      r_ill       <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= (op == OP_DIV);
      r_opnd   <= (op == OP_DIV) ? operand_b : operand_a;
      r_hi     <= '0;
      r_lo     <= (op == OP_DIV) ? operand_a : operand_b;
      if (!w_iter_op) begin
        r_result    <= w_res;
        r_result_hi <= w_res_hi;
        r_z         <= (w_res == '0);
        r_n         <= w_res[WIDTH-1];
        r_c         <= w_c;
        r_v         <= w_v;
        r_dz        <= w_dz;
        r_ill       <= w_ill;
      end
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      if (w_last_step) begin
        r_result    <= w_step_lo;
        r_result_hi <= w_step_hi;
        r_z         <= (w_step_lo == '0);
        r_n         <= w_step_lo[WIDTH-1];
        r_c         <= 1'b0;
        r_v         <= 1'b0;
        r_dz        <= 1'b0;
        r_ill       <= 1'b0;
      end
    end
  end

  assign out_valid     = (r_state == S_DONE);
  assign busy          = (r_state != S_IDLE);
  assign result        = r_result;
  assign result_hi     = r_result_hi;
  assign flag_zero     = r_z;
  assign flag_negative = r_n;
  assign flag_carry    = r_c;
  assign flag_overflow = r_v;
  assign flag_dz       = r_dz;
  assign flag_illegal  = r_ill;

endmodule
